// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - pattern write/read-back sequencer driving the sdram_controller CPU port
// Sweeps NUM_WORDS addresses: a write phase, then a compare read phase, optionally looping.
module sdram_pattern_tester #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 27,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          NUM_WORDS   = 256,
  parameter int unsigned ADDR_STRIDE = 8,
  parameter logic [31:0] PAT_A       = 32'h55,
  parameter logic [31:0] PAT_B       = 32'hAA,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1,
  parameter logic [31:0] LFSR_TAPS   = 32'h80200003,
  parameter int          TIMEOUT     = 1023,
  parameter int          ERR_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic              i_loop,
  input  logic              i_abort,
  input  logic              i_init_done,
  input  logic              i_busy,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_adv,
  output logic              o_rwn,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_running,
  output logic              o_phase,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [DATA_W-1:0] o_first_err_data,
  output logic [15:0]       o_pass_cnt
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] SEED     = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] TAPS     = DATA_W'(LFSR_TAPS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_INIT, S_ISSUE, S_WAIT_ACK, S_DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]        mode;
  logic [IDX_W-1:0]  idx;
  logic              phase;
  logic [DATA_W-1:0] lfsr;
  logic [TO_W-1:0]   tcnt;
  logic              aborted;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] lfsr_step;
  logic              start_take, active, issue_fire, in_wait;

  assign start_take = (state == S_IDLE || state == S_DONE) && i_start;
  assign active     = (state == S_WAIT_INIT || state == S_ISSUE || state == S_WAIT_ACK);
  assign issue_fire = (state == S_ISSUE) && !i_abort && !i_busy;
  assign in_wait    = (state == S_WAIT_ACK) && !i_abort;

  assign addr_cur  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
  assign lfsr_step = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? TAPS : '0);

  always_comb begin
    pattern = '0;
    case (mode)
      2'd0:    pattern = idx[0] ? DATA_W'(PAT_B) : DATA_W'(PAT_A);
      2'd1:    pattern = DATA_W'(addr_cur);
      2'd2:    pattern = DATA_W'(1) << (32'(idx) % DATA_W);
      default: pattern = lfsr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_nxt = S_WAIT_INIT;
      S_WAIT_INIT: begin
        if (i_abort)          state_nxt = S_DONE;
        else if (i_init_done) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_abort)      state_nxt = S_DONE;
        else if (!i_busy) state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (i_abort)
          state_nxt = S_DONE;
        else if (i_ack)
          state_nxt = (phase && idx == LAST_IDX && !i_loop) ? S_DONE : S_ISSUE;
        else if (tcnt == TO_LAST)
          state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode             <= '0;
      idx              <= '0;
      phase            <= 1'b0;
      lfsr             <= '0;
      tcnt             <= '0;
      aborted          <= 1'b0;
      o_adv            <= 1'b0;
      o_rwn            <= 1'b1;
      o_addr           <= '0;
      o_data           <= '0;
      o_timeout        <= 1'b0;
      o_err_cnt        <= '0;
      o_first_err_addr <= '0;
      o_first_err_data <= '0;
      o_pass_cnt       <= '0;
    end else begin
      o_adv <= issue_fire;
      if (start_take) begin
        mode             <= i_mode;
        idx              <= '0;
        phase            <= 1'b0;
        lfsr             <= SEED;
        aborted          <= 1'b0;
        o_timeout        <= 1'b0;
        o_err_cnt        <= '0;
        o_first_err_addr <= '0;
        o_first_err_data <= '0;
        o_pass_cnt       <= '0;
      end
      if (active && i_abort) aborted <= 1'b1;
      // Request fields stay frozen here until the next issue, covering the whole ack wait.
      if (issue_fire) begin
        o_addr <= addr_cur;
        o_data <= pattern;
        o_rwn  <= phase;
        lfsr   <= lfsr_step;
        tcnt   <= '0;
      end
      if (in_wait) begin
        if (i_ack) begin
          // o_data still holds the expected word for the read just completed.
          if (phase && i_data != o_data) begin
            if (o_err_cnt != {ERR_W{1'b1}}) o_err_cnt <= o_err_cnt + ERR_W'(1);
            if (o_err_cnt == '0) begin
              o_first_err_addr <= o_addr;
              o_first_err_data <= i_data;
            end
          end
          if (idx == LAST_IDX) begin
            idx  <= '0;
            lfsr <= SEED;
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              if (o_pass_cnt != 16'hFFFF) o_pass_cnt <= o_pass_cnt + 16'd1;
              if (i_loop) phase <= 1'b0;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end else if (tcnt == TO_LAST) begin
          o_timeout <= 1'b1;
        end else begin
          tcnt <= tcnt + TO_W'(1);
        end
      end
    end
  end

  assign o_phase   = phase;
  assign o_running = active;
  assign o_done    = (state == S_DONE);
  assign o_pass    = (state == S_DONE) && (o_err_cnt == '0) && !o_timeout && !aborted;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb/tb_sdram_pattern_tester.sv - directed bench with request-stream model and echo-memory controller BFM
module tb_sdram_pattern_tester;

  localparam int NW      = 40;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_loop, i_abort, i_init_done, i_busy, i_ack;
  logic [1:0]  i_mode;
  logic [31:0] i_data;
  logic        o_adv, o_rwn, o_running, o_phase, o_done, o_pass, o_timeout;
  logic [26:0] o_addr, o_first_err_addr;
  logic [31:0] o_data, o_first_err_data;
  logic [15:0] o_err_cnt, o_pass_cnt;

  sdram_pattern_tester #(
    .DATA_W(32), .ADDR_W(27), .BASE_ADDR(0), .NUM_WORDS(NW), .ADDR_STRIDE(8),
    .PAT_A(32'h55), .PAT_B(32'hAA), .LFSR_SEED(32'hACE1), .LFSR_TAPS(32'h80200003),
    .TIMEOUT(TIMEOUT), .ERR_W(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_loop(i_loop),
    .i_abort(i_abort), .i_init_done(i_init_done), .i_busy(i_busy), .i_ack(i_ack),
    .i_data(i_data), .o_adv(o_adv), .o_rwn(o_rwn), .o_addr(o_addr), .o_data(o_data),
    .o_running(o_running), .o_phase(o_phase), .o_done(o_done), .o_pass(o_pass),
    .o_timeout(o_timeout), .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr),
    .o_first_err_data(o_first_err_data), .o_pass_cnt(o_pass_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int test_id = 0;
  int seen_id = 0;
  int adv_n   = 0;
  logic [1:0]  m_mode = 2'd0;
  logic        hold = 1'b0, adv_prev = 1'b0;
  logic [59:0] hold_vec = '0;
  logic        busy_s = 1'b0, init_s = 1'b0, ack_s = 1'b0;
  logic [26:0] log_addr [4];
  logic [31:0] log_data [4];
  logic        bfm_noack = 1'b0;
  logic [26:0] corrupt_addr = '1;
  logic [31:0] mem [logic [26:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected write/read word for a given index, straight from the pattern-mode definitions.
  function automatic logic [31:0] exp_pattern(input logic [1:0] mode, input int idx);
    logic [31:0] l;
    case (mode)
      2'd0: return (idx % 2 == 0) ? 32'h55 : 32'hAA;
      2'd1: return 32'(idx * 8);
      2'd2: return 32'h1 << (idx % 32);
      default: begin
        l = 32'hACE1;
        for (int i = 0; i < idx; i++) l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        return l;
      end
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    busy_s = i_busy;
    init_s = i_init_done;
    ack_s  = i_ack;
    cyc++;
  end

  // Compare process: every request against the modelled sweep, and request fields held while waiting.
  initial forever begin
    int k, e_idx;
    logic e_phase;
    @(negedge clk);
    if (test_id != seen_id) begin
      seen_id  = test_id;
      adv_n    = 0;
      hold     = 1'b0;
      adv_prev = 1'b0;
    end
    if (!rst_n) begin
      hold     = 1'b0;
      adv_prev = 1'b0;
    end else begin
      if (hold && ack_s) hold = 1'b0;
      if (hold && o_running && !o_adv) check("req_hold", 64'({o_addr, o_rwn, o_data}), 64'(hold_vec));
      if (o_adv) begin
        k       = adv_n % (2 * NW);
        e_phase = (k >= NW);
        e_idx   = k % NW;
        check("adv_single", 64'(adv_prev), 64'(0));
        check("adv_gate", 64'({busy_s, init_s}), 64'(2'b01));
        check("req", 64'({o_addr, o_rwn, o_data}),
              64'({27'(e_idx * 8), e_phase, exp_pattern(m_mode, e_idx)}));
        if (adv_n < 4) begin
          log_addr[adv_n] = o_addr;
          log_data[adv_n] = o_data;
        end
        hold     = 1'b1;
        hold_vec = {o_addr, o_rwn, o_data};
        adv_n++;
      end
      adv_prev = o_adv;
    end
  end

  // Echo-memory controller: ack three cycles after the request, reads may be corrupted at one address.
  initial begin
    logic [26:0] b_addr;
    logic [31:0] b_data, rd;
    logic        b_rwn;
    i_ack  = 1'b0;
    i_data = '0;
    forever begin
      @(negedge clk);
      if (o_adv && rst_n && !bfm_noack) begin
        b_addr = o_addr;
        b_rwn  = o_rwn;
        b_data = o_data;
        repeat (2) @(negedge clk);
        if (b_rwn) begin
          rd = mem.exists(b_addr) ? mem[b_addr] : 32'h0;
          if (b_addr == corrupt_addr) rd = rd ^ 32'h1;
          i_data = rd;
        end else begin
          mem[b_addr] = b_data;
        end
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] mode);
    m_mode = mode;
    i_mode = mode;
    test_id++;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!o_done && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(o_done), 64'(1));
  endtask

  task automatic check_reset(input string name);
    check({name, "_flags"}, 64'({o_adv, o_rwn, o_running, o_phase, o_done, o_pass, o_timeout}), 64'(7'b0100000));
    check({name, "_req"}, 64'({o_addr, o_data}), 64'(0));
    check({name, "_cnt"}, 64'({o_err_cnt, o_pass_cnt}), 64'(0));
    check({name, "_first"}, 64'({o_first_err_addr, o_first_err_data}), 64'(0));
  endtask

  initial begin
    int n, t0, t1;
    rst_n = 1'b0; i_start = 1'b0; i_mode = 2'd0; i_loop = 1'b0; i_abort = 1'b0;
    i_init_done = 1'b0; i_busy = 1'b1;
    tick(3);
    check_reset("reset");
    rst_n = 1'b1;

    check("model_m0_odd", 64'(exp_pattern(2'd0, 3)), 64'(32'hAA));
    check("model_m2_idx10", 64'(exp_pattern(2'd2, 10)), 64'(32'h400));
    check("model_m2_wrap", 64'(exp_pattern(2'd2, 33)), 64'(32'h2));
    check("model_m3_step1", 64'(exp_pattern(2'd3, 1)), 64'(32'h80205673));

    // Mode 0 with init/busy gating and an ignored mid-test start.
    pulse_start(2'd0);
    tick(100);
    check("init_gate_adv", 64'(adv_n), 64'(0));
    check("init_gate_running", 64'(o_running), 64'(1));
    i_init_done = 1'b1;
    tick(5);
    check("busy_gate_adv", 64'(adv_n), 64'(0));
    i_busy = 1'b0;
    n = 0;
    while (adv_n < 10 && n < 200) begin @(negedge clk); n++; end
    i_mode = 2'd2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("m0_done", 2000);
    check("m0_result", 64'({o_pass, o_timeout, o_err_cnt, o_pass_cnt}), 64'({1'b1, 1'b0, 16'd0, 16'd1}));
    check("m0_adv_count", 64'(adv_n), 64'(2 * NW));
    check("m0_w0", 64'({log_addr[0], log_data[0]}), 64'({27'h0, 32'h55}));
    check("m0_w1", 64'({log_addr[1], log_data[1]}), 64'({27'h8, 32'hAA}));
    check("m0_w2", 64'({log_addr[2], log_data[2]}), 64'({27'h10, 32'h55}));
    check("m0_w3", 64'({log_addr[3], log_data[3]}), 64'({27'h18, 32'hAA}));
    check("m0_running", 64'(o_running), 64'(0));

    // Mode 2 with bit 0 corrupted on read of 0x50.
    corrupt_addr = 27'h50;
    pulse_start(2'd2);
    wait_done("m2_done", 2000);
    corrupt_addr = '1;
    check("m2_err_cnt", 64'(o_err_cnt), 64'(1));
    check("m2_first_addr", 64'(o_first_err_addr), 64'(27'h50));
    check("m2_first_data", 64'(o_first_err_data), 64'(32'h401));
    check("m2_pass", 64'(o_pass), 64'(0));

    // Mode 3 looping: two full passes then abort.
    i_loop = 1'b1;
    pulse_start(2'd3);
    n = 0;
    while (o_pass_cnt != 16'd2 && n < 3000) begin @(negedge clk); n++; end
    check("m3_two_passes", 64'(o_pass_cnt), 64'(2));
    check("m3_w0", 64'(log_data[0]), 64'(32'hACE1));
    check("m3_w1", 64'(log_data[1]), 64'(32'h80205673));
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_next_cycle", 64'({o_done, o_running}), 64'(2'b10));
    i_loop = 1'b0;
    tick(10);
    check("m3_final", 64'({o_pass, o_err_cnt, o_pass_cnt}), 64'({1'b0, 16'd0, 16'd2}));

    // No ack for the first write: timeout exactly TIMEOUT cycles after the request.
    bfm_noack = 1'b1;
    pulse_start(2'd0);
    n = 0;
    while (!o_adv && n < 50) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!o_timeout && n < 2 * TIMEOUT) begin @(negedge clk); n++; end
    t1 = cyc;
    check("timeout_cycles", 64'(t1 - t0), 64'(TIMEOUT));
    tick(5);
    check("timeout_result", 64'({o_done, o_pass, o_timeout}), 64'(3'b101));
    check("timeout_adv_once", 64'(adv_n), 64'(1));
    bfm_noack = 1'b0;

    // Reset during the read phase, then a clean rerun.
    pulse_start(2'd1);
    n = 0;
    while (!(o_phase && adv_n >= 45) && n < 1000) begin @(negedge clk); n++; end
    check("m1_in_read", 64'(o_phase), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("midreset");
    test_id++;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    pulse_start(2'd1);
    wait_done("m1_done", 2000);
    check("m1_result", 64'({o_pass, o_err_cnt, o_pass_cnt}), 64'({1'b1, 16'd0, 16'd1}));
    check("m1_adv_count", 64'(adv_n), 64'(2 * NW));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
